// File: rtl/rv32_core_pkg.sv
// Shared FIFO definitions: occupancy status encoding and its derivation
// from the empty/full pointer comparisons.
package rv32_core_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_status_e;

    function automatic fifo_status_e fifo_status(input logic ptr_equal, input logic ptr_wrapped);
        if (ptr_equal) begin
            return FIFO_EMPTY;
        end
        if (ptr_wrapped) begin
            return FIFO_FULL;
        end
        return FIFO_PARTIAL;
    endfunction

endpackage

// File: rtl/rv32_fifo_ptr.sv
// Wrapping FIFO pointer with one extra MSB so full and empty can be told apart.
module rv32_fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_inc,
    input  logic                    i_clr,
    output logic [$clog2(DEPTH):0]  o_ptr
);

    logic [$clog2(DEPTH):0] ptr_reg;
    logic [$clog2(DEPTH):0] ptr_next;

    // DEPTH is a power of two, so the carry out of the index bits
    // toggles the MSB exactly when the index wraps from DEPTH-1 to 0.
    assign ptr_next = ptr_reg + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg <= '0;
        end else if (i_clr) begin
            ptr_reg <= '0;
        end else if (i_inc) begin
            ptr_reg <= ptr_next;
        end
    end

    assign o_ptr = ptr_reg;

endmodule

// File: rtl/rv32_elastic_fifo.sv
// Valid/ready elastic FIFO with flush and almost-full flag.
// Define RV32_ELASTIC_FIFO_BYPASS_EN for zero-latency fall-through when empty.
module rv32_elastic_fifo
    import rv32_core_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 4,
    parameter int               AFULL_THRESH = 3,
    parameter logic [WIDTH-1:0] RST_DATA     = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic [WIDTH-1:0]            i_din_recv,
    input  logic                        i_valid_recv,
    output logic                        o_ready_recv,
    output logic [WIDTH-1:0]            o_dout_send,
    output logic                        o_valid_send,
    input  logic                        i_ready_send,
    output logic [$clog2(DEPTH+1)-1:0]  o_count,
    output logic                        o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] AFULL_LVL = CW'(AFULL_THRESH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rv32_elastic_fifo: DEPTH must be a power of two >= 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("rv32_elastic_fifo: AFULL_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      fill;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;
    fifo_status_e     status;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign status = fifo_status(wr_ptr == rd_ptr,
                                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]));
    assign empty  = (status == FIFO_EMPTY);
    assign full   = (status == FIFO_FULL);

    assign fill          = wr_ptr - rd_ptr;
    assign o_count       = CW'(fill);
    assign o_almost_full = (o_count >= AFULL_LVL);
    assign o_ready_recv  = !full && !i_flush;

    // Head is read combinationally so a word written at edge N is on
    // o_dout_send right after edge N.
    assign head = mem[rd_ptr[AW-1:0]];

`ifdef RV32_ELASTIC_FIFO_BYPASS_EN
    assign o_valid_send = !i_flush && (empty ? i_valid_recv : 1'b1);
    assign o_dout_send  = !o_valid_send ? RST_DATA : (empty ? i_din_recv : head);
    // An empty FIFO with a ready consumer hands the word straight through.
    assign push = i_valid_recv && o_ready_recv && !(empty && i_ready_send);
    assign pop  = o_valid_send && i_ready_send && !empty;
`else
    assign o_valid_send = !empty && !i_flush;
    assign o_dout_send  = o_valid_send ? head : RST_DATA;
    assign push = i_valid_recv && o_ready_recv;
    assign pop  = o_valid_send && i_ready_send;
`endif

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_din_recv;
        end
    end

    rv32_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (push),
        .i_clr   (i_flush),
        .o_ptr   (wr_ptr)
    );

    rv32_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (pop),
        .i_clr   (i_flush),
        .o_ptr   (rd_ptr)
    );

endmodule

// File: doc/rv32_elastic_fifo.md
RV32_ELASTIC_FIFO -- requirements
Module: rv32_elastic_fifo

Interface
REQ-001 The block SHALL have one clock and one reset. The reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH, default 32: payload width in bits.
REQ-003 Parameter DEPTH, default 4: number of entries; power of two, >= 2.
REQ-004 Parameter AFULL_THRESH, default 3: occupancy at which o_almost_full asserts; range 1..DEPTH.
REQ-005 Parameter RST_DATA, default 0: value driven on o_dout_send whenever o_valid_send is 0.
REQ-006 Port i_clk  input  1  clock; all state changes on the rising edge.
REQ-007 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 Port i_flush  input  1  synchronous discard of all contents.
REQ-009 Port i_din_recv  input  WIDTH  producer payload.
REQ-010 Port i_valid_recv  input  1  producer valid.
REQ-011 Port o_ready_recv  output  1  FIFO can accept a push.
REQ-012 Port o_dout_send  output  WIDTH  head payload to the consumer.
REQ-013 Port o_valid_send  output  1  head payload is valid.
REQ-014 Port i_ready_send  input  1  consumer ready.
REQ-015 Port o_count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 Port o_almost_full  output  1  asserted when o_count >= AFULL_THRESH.

Function
REQ-017 A push SHALL occur on an edge where i_valid_recv && o_ready_recv; a pop SHALL occur on an edge where o_valid_send && i_ready_send.
REQ-018 o_ready_recv SHALL be !full && !i_flush, and SHALL have no combinational path from i_ready_send.
REQ-019 o_valid_send SHALL be (o_count != 0) && !i_flush.
REQ-020 When o_valid_send is 1, o_dout_send SHALL equal the oldest stored entry. Otherwise it SHALL equal RST_DATA.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap from DEPTH-1 to 0 by toggling the MSB.
REQ-022 Empty SHALL be defined as pointers equal. Full SHALL be defined as low bits equal with MSBs different.
REQ-023 Latency SHALL be 1 cycle: data pushed at edge N is visible on o_dout_send after edge N.
REQ-024 Push without pop SHALL increment o_count, and pop without push SHALL decrement it. Simultaneous push and pop SHALL leave it unchanged, including at DEPTH-1 and at 1.
REQ-025 When full, o_ready_recv SHALL be 0 and i_valid_recv SHALL be ignored. When empty, no pop SHALL occur.
REQ-026 Full throughput SHALL be sustained: one push and one pop per cycle at any occupancy from 1 to DEPTH-1.
REQ-027 i_flush SHALL take priority over push and pop: at the next edge, pointers and o_count become 0 and the flush-cycle input is dropped.
REQ-028 Entry order SHALL be strictly first-in first-out; no entry SHALL be dropped or duplicated outside a flush.

Reset
REQ-029 On i_rst_n low, pointers and o_count SHALL become 0 immediately, independent of the clock.
REQ-030 During and after reset, outputs SHALL be: o_valid_send=0, o_dout_send=RST_DATA, o_ready_recv=1, o_almost_full=0.
REQ-031 Storage entries SHALL NOT be reset.
REQ-032 A reset asserted mid-transfer SHALL discard all contents. The first push after deassertion SHALL be the next head.

Configuration
REQ-033 Macro RV32_ELASTIC_FIFO_BYPASS_EN SHALL select fall-through behaviour.
- Defined, empty FIFO, not in flush: o_valid_send = i_valid_recv and o_dout_send = i_din_recv, combinationally.
- If i_ready_send is also 1 in that case, the word SHALL be consumed with no storage write and o_count SHALL stay 0.
- Defined, empty FIFO, i_ready_send = 0: the word SHALL be stored as usual.
REQ-034 With the macro undefined, behaviour SHALL be exactly REQ-019 and REQ-020, with 1-cycle minimum latency.

Structure
REQ-035 Shared package rv32_core_pkg SHALL hold typedef enum fifo_status_e {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL}, which is used internally and by bench assertions.
REQ-036 Pointer increment and wrap SHALL be a sub-module rv32_fifo_ptr (parameter DEPTH; inputs i_clk, i_rst_n, i_inc, i_clr; output pointer).
REQ-037 Elaboration SHALL fail if DEPTH is not a power of two >= 2, or if AFULL_THRESH is outside 1..DEPTH.

Verification
REQ-038 Fill: DEPTH=4, push 0xA0..0xA3 with i_ready_send=0.
- Expected: o_count=4, o_ready_recv=0, o_almost_full=1 from 3 entries onward.
- A fifth push of 0xA4 is ignored.
REQ-039 Drain: from the full state, hold i_ready_send=1.
- Expected: outputs 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles, then o_valid_send=0 and o_dout_send=RST_DATA.
REQ-040 Streaming: 64 words with i_valid_recv=i_ready_send=1.
- Expected: one transfer per cycle, o_count steady at 1 (0 with BYPASS_EN), in-order output, pointer wrap crossed 16 times.
REQ-041 Flush: with 3 entries, pulse i_flush with i_valid_recv=1 and data 0x55.
- Expected: next cycle o_count=0 and 0x55 is never output.
REQ-042 Async reset: assert i_rst_n=0 between clock edges with 2 entries stored.
- Expected: o_valid_send=0 and o_count=0 before the next edge.
- The first push after release (0x77) is the first word output.
REQ-043 Bypass (macro defined): empty FIFO, i_valid_recv=i_ready_send=1, data 0x3C.
- Expected: o_dout_send=0x3C in the same cycle and o_count stays 0.
